// File: rtl/opstack_pkg.sv
/*----------------------------------------------------------------
 * opstack_pkg : opcodes and cell select codes for operand_stack
 * Rev 1.0
 *--------------------------------------------------------------*/
`default_nettype none

package opstack_pkg;

  localparam int OPSTACK_W = 16;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_CLEAR = 3'b011,
    OP_SWAP  = 3'b100
  } opcode_t;

  // Next-value source for a stack cell.
  typedef enum logic [1:0] {
    SEL_DOWN = 2'd0,
    SEL_UP   = 2'd1,
    SEL_SWAP = 2'd2
  } sel_t;

endpackage

`default_nettype wire

// File: rtl/opstack_cell.sv
/*----------------------------------------------------------------
 * opstack_cell : one stack entry with load, wipe and source select
 * Swap source present only with OPSTACK_SWAP_EN.   Rev 1.0
 *--------------------------------------------------------------*/
`default_nettype none

module opstack_cell
  import opstack_pkg::*;
#(
  parameter int WIDTH = OPSTACK_W
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             load,
  input  logic             wipe,
  input  sel_t             sel,
  input  logic [WIDTH-1:0] d_down,
  input  logic [WIDTH-1:0] d_up,
`ifdef OPSTACK_SWAP_EN
  input  logic [WIDTH-1:0] d_swap,
`endif
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = d_down;
    if (sel == SEL_UP) w_next = d_up;
`ifdef OPSTACK_SWAP_EN
    if (sel == SEL_SWAP) w_next = d_swap;
`endif
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)      q <= '0;
    else if (wipe) q <= '0;
    else if (load) q <= w_next;
  end

endmodule

`default_nettype wire

// File: rtl/operand_stack.sv
/*----------------------------------------------------------------
 * operand_stack : LIFO operand stack with sticky ovf/unf flags
 * Optional SWAP via OPSTACK_SWAP_EN.   Rev 1.0
 *--------------------------------------------------------------*/
`default_nettype none

module operand_stack
  import opstack_pkg::*;
#(
  parameter int WIDTH = OPSTACK_W,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic [WIDTH-1:0]           din,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] w_ent [DEPTH];
  logic [DEPTH-1:0] w_load;
  logic             w_wipe;
  sel_t             w_sel;
  opcode_t          w_op;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_ovf, r_unf;
  logic             w_ovf_set, w_unf_set;
  logic             w_full, w_empty;

  assign w_op    = opcode_t'(cmd);
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_load    = '0;
    w_wipe    = 1'b0;
    w_sel     = SEL_DOWN;
    w_cnt_nxt = r_count;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (cmd_valid) begin
      case (w_op)
        OP_PUSH: begin
          if (w_full) w_ovf_set = 1'b1;
          else begin
            w_load    = '1;
            w_sel     = SEL_DOWN;
            w_cnt_nxt = r_count + CW'(1);
          end
        end
        OP_POP: begin
          if (w_empty) w_unf_set = 1'b1;
          else begin
            w_load    = '1;
            w_sel     = SEL_UP;
            w_cnt_nxt = r_count - CW'(1);
          end
        end
        OP_CLEAR: begin
          w_wipe    = 1'b1;
          w_cnt_nxt = '0;
        end
        OP_SWAP: begin
`ifdef OPSTACK_SWAP_EN
          if (r_count >= CW'(2)) begin
            w_load = DEPTH'(3);
            w_sel  = SEL_SWAP;
          end else begin
            w_unf_set = 1'b1;
          end
`else
          w_unf_set = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Shift chain: din enters at entry 0, zeros enter at the bottom on pop.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] w_down, w_up;
    if (i == 0) begin : g_first
      assign w_down = din;
    end else begin : g_chain_dn
      assign w_down = w_ent[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign w_up = '0;
    end else begin : g_chain_up
      assign w_up = w_ent[i+1];
    end
`ifdef OPSTACK_SWAP_EN
    logic [WIDTH-1:0] w_swp;
    if (i < 2) begin : g_swp_pair
      assign w_swp = w_ent[1-i];
    end else begin : g_swp_hold
      assign w_swp = w_ent[i];
    end
`endif
    opstack_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK    (CLK),
      .CLR    (CLR),
      .load   (w_load[i]),
      .wipe   (w_wipe),
      .sel    (w_sel),
      .d_down (w_down),
      .d_up   (w_up),
`ifdef OPSTACK_SWAP_EN
      .d_swap (w_swp),
`endif
      .q      (w_ent[i])
    );
  end

  // Error set wins over a simultaneous err_clr.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf   <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  assign top    = w_ent[0];
  assign second = w_ent[1];
  assign count  = r_count;
  assign full   = w_full;
  assign empty  = w_empty;
  assign ovf    = r_ovf;
  assign unf    = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_operand_stack.sv
/*----------------------------------------------------------------
 * tb_operand_stack : directed plus random checks against a queue model
 *--------------------------------------------------------------*/
`default_nettype none

module tb_operand_stack;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          CLK = 1'b0;
  logic          CLR;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [W-1:0]  din;
  logic          err_clr;
  logic [W-1:0]  top, second;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_q[$];
  bit           m_ovf, m_unf;

  always #5 CLK = ~CLK;

  operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .CLR(CLR), .cmd_valid(cmd_valid), .cmd(cmd), .din(din),
    .err_clr(err_clr), .top(top), .second(second), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("top",    32'(top),    32'(m_q.size() > 0 ? m_q[0] : '0));
    chk("second", 32'(second), 32'(m_q.size() > 1 ? m_q[1] : '0));
    chk("count",  32'(count),  32'(m_q.size()));
    chk("full",   32'(full),   32'(m_q.size() == D));
    chk("empty",  32'(empty),  32'(m_q.size() == 0));
    chk("ovf",    32'(ovf),    32'(m_ovf));
    chk("unf",    32'(unf),    32'(m_unf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_apply(input bit v, input logic [2:0] c, input logic [W-1:0] d, input bit e);
    bit so, su;
    logic [W-1:0] t;
    so = 0; su = 0;
    if (v) begin
      case (c)
        3'd1: if (m_q.size() == D) so = 1; else m_q.push_front(d);
        3'd2: if (m_q.size() == 0) su = 1; else void'(m_q.pop_front());
        3'd3: m_q.delete();
        3'd4: begin
`ifdef OPSTACK_SWAP_EN
          if (m_q.size() >= 2) begin
            t = m_q[0]; m_q[0] = m_q[1]; m_q[1] = t;
          end else su = 1;
`else
          su = 1;
`endif
        end
        default: ;
      endcase
    end
    m_ovf = so || (m_ovf && !e);
    m_unf = su || (m_unf && !e);
  endtask

  task automatic cyc(input bit v, input logic [2:0] c, input logic [W-1:0] d, input bit e);
    @(negedge CLK);
    cmd_valid = v; cmd = c; din = d; err_clr = e;
    @(posedge CLK);
    model_apply(v, c, d, e);
    #1;
    check_model();
  endtask

  initial begin
    CLR = 1'b0; cmd_valid = 0; cmd = 0; din = 0; err_clr = 0;
    model_reset();
    #2;
    check_model();
    @(negedge CLK);
    CLR = 1'b1;

    cyc(1, 3'd1, 16'h3C00, 0);
    cyc(1, 3'd1, 16'h4000, 0);
    cyc(1, 3'd1, 16'h4200, 0);
    chk("plan_top3",    32'(top),    32'h4200);
    chk("plan_second3", 32'(second), 32'h4000);
    chk("plan_count3",  32'(count),  32'd3);
    cyc(1, 3'd2, 16'h0, 0);
    chk("plan_pop_top", 32'(top),    32'h4000);
    chk("plan_pop_cnt", 32'(count),  32'd2);

    cyc(1, 3'd1, 16'h4400, 0);
    cyc(1, 3'd1, 16'h4500, 0);
    cyc(1, 3'd1, 16'h4600, 0);
    chk("plan_full", 32'(full), 32'd1);
    chk("plan_ovf",  32'(ovf),  32'd1);
    chk("plan_ovf_top", 32'(top), 32'h4500);
    cyc(0, 3'd0, 16'h0, 1);
    chk("plan_ovf_clr", 32'(ovf), 32'd0);

    cyc(1, 3'd2, 16'h0, 0);
    chk("plan_pre_rst_cnt", 32'(count), 32'd3);
    #2;
    CLR = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge CLK);
    CLR = 1'b1;

    cyc(1, 3'd2, 16'h0, 1);
    chk("plan_unf_setwins", 32'(unf), 32'd1);
    cyc(0, 3'd0, 16'h0, 1);

    cyc(1, 3'd1, 16'h3C00, 0);
    cyc(1, 3'd1, 16'h4400, 0);
    cyc(1, 3'd4, 16'h0, 0);
`ifdef OPSTACK_SWAP_EN
    chk("plan_swap_top", 32'(top),    32'h3C00);
    chk("plan_swap_sec", 32'(second), 32'h4400);
`else
    chk("plan_swap_top", 32'(top), 32'h4400);
    chk("plan_swap_unf", 32'(unf), 32'd1);
`endif

    cyc(1, 3'd1, 16'h1111, 0);
    cyc(1, 3'd1, 16'h2222, 0);
    cyc(1, 3'd1, 16'h3333, 0);
    cyc(1, 3'd3, 16'h0, 0);
    cyc(1, 3'd1, 16'h4500, 0);
    chk("plan_clr_cnt", 32'(count),  32'd1);
    chk("plan_clr_top", 32'(top),    32'h4500);
    chk("plan_clr_sec", 32'(second), 32'h0);
    chk("plan_clr_ovf", 32'(ovf),    32'd1);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 99) < 85, c, W'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Parametrised LIFO operand stack for the floating-point calculator datapath.
- Generalises the single N-bit register to DEPTH entries of WIDTH bits.
- Supports push, pop and clear-all commands, with full/empty status and sticky error flags.
- Sits between the keypad/operand-entry logic and the FP arithmetic unit, which reads the top two entries as operands.

Parameters:
- WIDTH, 16, bit width of each stack entry (one FP operand).
- DEPTH, 4, number of entries; legal range 2..32.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command strobe; cmd is sampled only when high.
- cmd  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 CLEAR_ALL, 100 SWAP; others reserved.
- din  in  WIDTH  data to push.
- err_clr  in  1  clears the sticky error flags.
- top  out  WIDTH  entry 0, the top of stack.
- second  out  WIDTH  entry 1.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow / illegal-operation flag.

Behaviour:
- Reset:
  - Reset CLR, asynchronous, active-low; clock CLK.
  - CLR low: all entries, count, ovf and unf go to 0 immediately; empty=1, full=0.
  - Release is synchronous to the next rising CLK edge.
- Storage and latency:
  - Storage is a shift array; entry 0 is the top.
  - All state updates on the rising CLK edge when cmd_valid=1.
  - Outputs are registered or derived directly from registered state; results are visible one cycle after the command.
- PUSH:
  - Not full: entries shift down (entry i+1 <= entry i), entry 0 <= din, count+1.
  - Full: no state change, ovf <= 1.
- POP:
  - Not empty: entries shift up (entry i <= entry i+1), last entry <= 0, count-1.
  - Empty: no state change, unf <= 1.
- CLEAR_ALL:
  - All entries <= 0, count <= 0.
  - Flags are unchanged.
- SWAP: see Optional Feature.
- NOP, reserved opcodes and cmd_valid=0: no change.
- Vacated entries are always zero, so second reads 0 when count < 2.
- Flag timing:
  - err_clr clears ovf/unf on the clock edge.
  - If an error event occurs in the same cycle as err_clr, set wins and the flag reads 1.
- count never wraps: it saturates at DEPTH and at 0.
- Back-to-back commands on every cycle are supported with no bubbles.

Optional Feature:
- Macro: OPSTACK_SWAP_EN.
- Defined:
  - SWAP with count >= 2 exchanges entry 0 and entry 1; count is unchanged.
  - SWAP with count < 2 makes no change and sets unf.
- Undefined:
  - No swap hardware is generated.
  - SWAP opcode 100 is treated as an illegal operation: no state change, unf <= 1.

Decomposition:
- Package opstack_pkg holds:
  - typedef enum logic [2:0] opcode_t (OP_NOP, OP_PUSH, OP_POP, OP_CLEAR, OP_SWAP);
  - default width constant OPSTACK_W = 16.
- One sub-module, opstack_cell:
  - one WIDTH-bit entry with load enable, a 2:1 (3:1 with swap) next-value select, and asynchronous active-low clear;
  - instantiated DEPTH times via generate.

Test Plan:
- Reset: drive CLR=0 mid-operation with count=3 -> count=0, top=0, empty=1, ovf=unf=0 before the next edge.
- Push and pop order: PUSH 0x3C00, 0x4000, 0x4200 -> top=0x4200, second=0x4000, count=3; POP -> top=0x4000, count=2.
- Overflow: PUSH 5 values into DEPTH=4 -> full=1, count=4, top is the 4th value, ovf=1; err_clr -> ovf=0.
- Underflow and set-wins: with empty=1, POP together with err_clr asserted -> unf=1, count=0.
- SWAP with OPSTACK_SWAP_EN:
  - stack {top=0x4400, second=0x3C00} -> top=0x3C00, second=0x4400;
  - without the macro -> unchanged, unf=1.
- CLEAR_ALL and back-to-back: with ovf=1, CLEAR_ALL then PUSH 0x4500 on consecutive cycles -> count=1, top=0x4500, second=0, ovf still 1.
